// File: rtl/mac_readout.sv
// rtl/mac_readout.sv - MAC bank readout sequencer: sample hold, pipelined bank read, output FIFO
// Optional post-readout bank clear is built when READOUT_CLR_EN is defined.
module mac_readout #(
  parameter int N_LAGS       = 32,
  parameter int AW           = 5,
  parameter int GUARD_CYCLES = 34,
  parameter int DEPTH        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          sin_hold,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data,
  output logic          bank_clr,
  output logic [31:0]   dout,
  output logic [AW-1:0] dout_idx,
  output logic          dout_last,
  output logic          dout_valid,
  input  logic          dout_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GUARD = 3'd1;
  localparam logic [2:0] S_OPEN  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
`ifdef READOUT_CLR_EN
  localparam logic [2:0] S_CLR   = 3'd5;
  localparam logic [2:0] S_CWAIT = 3'd6;
`endif

  localparam int CMAX = (GUARD_CYCLES > N_LAGS + 1) ? GUARD_CYCLES : N_LAGS + 1;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam int OW   = $clog2(DEPTH + 1);
  localparam int OW1  = OW + 1;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr;

  // Two-stage in-flight tracker matching the bank's two-edge read latency
  logic          s0_v, s1_v;
  logic [AW-1:0] s0_idx, s1_idx;

  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] fifo_idx  [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;

  logic [OW1-1:0] load_sum;
  logic           issue, capture, pop, last_addr, drained;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reserving FIFO slots for in-flight words makes overflow impossible
  assign load_sum  = OW1'(occ) + OW1'(s0_v) + OW1'(s1_v);
  assign issue     = (state == S_ISSUE) && (load_sum < OW1'(DEPTH));
  assign capture   = s1_v;
  assign pop       = dout_valid && dout_ready;
  assign last_addr = (addr == AW'(N_LAGS - 1));
  assign drained   = !s0_v && !s1_v && (occ == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_GUARD;
            cnt   <= '0;
            addr  <= '0;
          end
        end
        S_GUARD: begin
          if (cnt == CW'(GUARD_CYCLES - 1)) begin
            state <= S_OPEN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_OPEN:  state <= S_ISSUE;
        S_ISSUE: begin
          if (issue) begin
            if (last_addr) state <= S_DRAIN;
            else           addr  <= addr + AW'(1);
          end
        end
        S_DRAIN: begin
          if (drained) begin
`ifdef READOUT_CLR_EN
            state <= S_CLR;
`else
            state <= S_IDLE;
`endif
          end
        end
`ifdef READOUT_CLR_EN
        S_CLR: begin
          state <= S_CWAIT;
          cnt   <= '0;
        end
        S_CWAIT: begin
          if (cnt == CW'(N_LAGS)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v   <= 1'b0;
      s1_v   <= 1'b0;
      s0_idx <= '0;
      s1_idx <= '0;
    end else begin
      s0_v   <= issue;
      s0_idx <= addr;
      s1_v   <= s0_v;
      s1_idx <= s0_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (capture) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({capture, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // At full occupancy wr_ptr equals rd_ptr; the head is read before this write lands
  always_ff @(posedge clk) begin
    if (capture) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_idx[wr_ptr]  <= s1_idx;
    end
  end

  assign busy       = (state != S_IDLE);
  assign sin_hold   = busy;
  assign rd_en      = (state == S_OPEN) || (state == S_ISSUE) ||
                      ((state == S_DRAIN) && (s0_v || s1_v));
  assign rd_addr    = addr;
`ifdef READOUT_CLR_EN
  assign bank_clr   = (state == S_CLR);
`else
  assign bank_clr   = 1'b0;
`endif
  assign dout_valid = (occ != '0);
  assign dout       = dout_valid ? fifo_data[rd_ptr] : '0;
  assign dout_idx   = dout_valid ? fifo_idx[rd_ptr] : '0;
  assign dout_last  = dout_valid && (fifo_idx[rd_ptr] == AW'(N_LAGS - 1));

endmodule

// File: tb/tb_mac_readout.sv
// tb/tb_mac_readout.sv - randomized bench for mac_readout against a lag-bank model and word scoreboard
module tb_mac_readout;
  localparam int N     = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, dout_ready = 1'b0, sin = 1'b0, load = 1'b0;
  logic busy, sin_hold, rd_en, bank_clr, dout_valid, dout_last;
  logic [AW-1:0] rd_addr, dout_idx;
  logic [31:0] rd_data, dout, pipe;
  logic [31:0] mem [N];
  logic [31:0] load_vals [N];
  logic [31:0] exp_words [N];

  typedef struct packed {
    logic          last;
    logic [AW-1:0] idx;
    logic [31:0]   data;
  } word_t;
  word_t got_q[$];

  int errors = 0, checks = 0;
  int ready_mode = 0, cyc = 0, pop_cnt = 0, clr_cnt = 0;
  bit sin_en = 0, addr_bad = 0, stall_bad = 0, hold_bad = 0, prev_stall = 0;
  logic [31:0] prev_dout;
  logic [AW-1:0] prev_idx;

  always #5 clk = ~clk;

  mac_readout #(.N_LAGS(N), .AW(AW), .GUARD_CYCLES(34), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .sin_hold(sin_hold),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .bank_clr(bank_clr),
    .dout(dout), .dout_idx(dout_idx), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  // Lag bank: each unheld sample strobe adds i+1 to lag i; reads take two edges
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) mem[i] <= load_vals[i];
    end else if (bank_clr) begin
      for (int i = 0; i < N; i++) mem[i] <= 32'd0;
    end else if (sin && !sin_hold) begin
      for (int i = 0; i < N; i++) mem[i] <= mem[i] + 32'(i + 1);
    end
    if (rd_en) pipe <= mem[rd_addr];
    rd_data <= pipe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = (cyc % 3 == 0);
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      sin = sin_en && busy && (cyc % 5 == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (sin_hold !== busy) hold_bad = 1;
        if (busy && int'(rd_addr) > pop_cnt + DEPTH) addr_bad = 1;
        if (prev_stall && (!dout_valid || dout !== prev_dout || dout_idx !== prev_idx)) stall_bad = 1;
        prev_stall = dout_valid && !dout_ready;
        prev_dout  = dout;
        prev_idx   = dout_idx;
        if (bank_clr) clr_cnt++;
        if (dout_valid && dout_ready) begin
          got_q.push_back('{last: dout_last, idx: dout_idx, data: dout});
          pop_cnt++;
        end
      end
    end
  end

  task automatic preload();
    for (int i = 0; i < N; i++) exp_words[i] = load_vals[i];
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic rand_load();
    for (int i = 0; i < N; i++) load_vals[i] = $urandom;
    preload();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic kick();
    pop_cnt = 0;
    got_q.delete();
    pulse_start();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(busy), 0);
    repeat (4) @(negedge clk);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, got_q.size(), N);
    for (int i = 0; i < got_q.size() && i < N; i++) begin
      check({tag, "_data"}, got_q[i].data, exp_words[i]);
      check({tag, "_idx"},  32'(got_q[i].idx), i);
      check({tag, "_last"}, 32'(got_q[i].last), 32'(i == N - 1));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_hold"},  32'(sin_hold), 0);
    check({tag, "_rden"},  32'(rd_en), 0);
    check({tag, "_clr"},   32'(bank_clr), 0);
    check({tag, "_valid"}, 32'(dout_valid), 0);
    check({tag, "_last"},  32'(dout_last), 0);
    check({tag, "_addr"},  32'(rd_addr), 0);
    check({tag, "_dout"},  dout, 0);
    check({tag, "_idx"},   32'(dout_idx), 0);
  endtask

  initial begin
    int n;
    int hb;
    #1;
    check_reset_state("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) load_vals[i] = 32'(i * 3 + 7);
    preload();
    ready_mode = 0;
    kick();
    wait_idle("seq");
    compare("seq");

    preload();
    ready_mode = 1;
    addr_bad = 0;
    stall_bad = 0;
    kick();
    wait_idle("slow");
    compare("slow");
    check("slow_addr_vs_full", 32'(addr_bad), 0);
    check("slow_dout_hold", 32'(stall_bad), 0);

    for (int r = 0; r < 3; r++) begin
      rand_load();
      ready_mode = 2;
      kick();
      wait_idle("rand");
      compare("rand");
    end
    check("rand_addr_vs_full", 32'(addr_bad), 0);
    check("rand_dout_hold", 32'(stall_bad), 0);

    rand_load();
    ready_mode = 2;
    sin_en = 1;
    kick();
    wait_idle("gate");
    sin_en = 0;
    compare("gate");
    for (int i = 0; i < N; i++) begin
`ifdef READOUT_CLR_EN
      check("gate_bank", mem[i], 0);
`else
      check("gate_bank", mem[i], exp_words[i]);
`endif
    end

`ifdef READOUT_CLR_EN
    rand_load();
    ready_mode = 0;
    clr_cnt = 0;
    kick();
    wait_idle("clr1");
    compare("clr1");
    check("clr1_pulses", clr_cnt, 1);
    for (int i = 0; i < N; i++) exp_words[i] = 32'd0;
    kick();
    wait_idle("clr2");
    compare("clr2");
    check("clr2_pulses", clr_cnt, 2);
`endif

    rand_load();
    ready_mode = 0;
    kick();
    n = 0;
    while (!(busy && rd_addr == AW'(10)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach", 32'(n < 2000), 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_state("abort");
    for (int i = 0; i < got_q.size(); i++) begin
      check("abort_prefix_data", got_q[i].data, exp_words[i]);
      check("abort_prefix_idx", 32'(got_q[i].idx), i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_stale", got_q.size(), 0);
    kick();
    wait_idle("fresh");
    compare("fresh");

    preload();
    ready_mode = 1;
    kick();
    repeat (5) @(posedge clk);
    pulse_start();
    n = 0;
    while (!(busy && rd_addr == AW'(N - 1)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("restart_reach", 32'(n < 2000), 1);
    repeat (6) @(posedge clk);
    pulse_start();
    wait_idle("restart");
    compare("restart");
    hb = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy) hb++;
    end
    check("restart_ignored", hb, 0);
    check("restart_count", got_q.size(), N);

    check("hold_eq_busy", 32'(hold_bad), 0);
`ifndef READOUT_CLR_EN
    check("no_bank_clr", clr_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_readout.md
MAC_READOUT -- requirements
Module: mac_readout

Interface
REQ-001 Parameter N_LAGS, default 32, number of lag words per readout; SHALL be a power of two.
REQ-002 Parameter AW, default 5, address width; SHALL equal log2(N_LAGS).
REQ-003 Parameter GUARD_CYCLES, default 34, cycles waited after sin_hold rises before read is asserted.
REQ-004 Parameter DEPTH, default 4, output buffer depth; SHALL be at least 3.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle request for a full readout of the MAC bank.
REQ-008 busy  output  1  high from start acceptance until the return to IDLE.
REQ-009 sin_hold  output  1  high while busy; upstream SHALL gate the bank sample strobe with it.
REQ-010 rd_en  output  1  drives the bank read enable.
REQ-011 rd_addr  output  AW  drives the bank read address.
REQ-012 rd_data  input  32  registered bank read data.
REQ-013 bank_clr  output  1  drives the bank sync clear (CLR_EN builds only; tied 0 otherwise).
REQ-014 dout  output  32  lag word; dout_idx  output  AW  its lag index; dout_last  output  1  high on index N_LAGS-1.
REQ-015 dout_valid  output  1 / dout_ready  input  1  valid/ready stream handshake.

Function
REQ-016 States: IDLE, GUARD, OPEN, ISSUE, DRAIN, CLR, CWAIT.
REQ-017 IDLE: start=1 -> GUARD; start is ignored in every other state.
REQ-018 GUARD: sin_hold=1, rd_en=0; counts GUARD_CYCLES cycles, then -> OPEN.
REQ-019 OPEN: rd_en=1 for one cycle (bank enters its read state); -> ISSUE.
REQ-020 ISSUE: rd_en=1; one address per cycle, 0 to N_LAGS-1, issued only when buffer occupancy plus in-flight count < DEPTH; rd_addr holds its value while stalled.
REQ-021 Read latency: rd_data sampled at edge k+2 corresponds to the rd_addr sampled at edge k; in-flight tracking uses a 2-stage valid shift register carrying the index.
REQ-022 After address N_LAGS-1 is issued -> DRAIN; rd_en stays 1 until the last word is captured, then drops to 0.
REQ-023 Output buffer: FIFO of DEPTH entries {data, idx}; dout_valid = not empty; pop on dout_valid & dout_ready; overflow SHALL be impossible by construction.
REQ-024 Capture and pop in the same cycle at full occupancy SHALL be legal and lossless.
REQ-025 DRAIN exits once the buffer is empty and no word is in flight: -> CLR if CLR_EN, else -> IDLE.
REQ-026 Every lag word SHALL be emitted exactly once, in ascending index order.
REQ-027 dout retains the FIFO head value while dout_valid=1 and dout_ready=0.

Reset
REQ-028 On rst_n=0: state IDLE; busy, sin_hold, rd_en, bank_clr, dout_valid, dout_last = 0; rd_addr, dout, dout_idx = 0; FIFO and in-flight register emptied.
REQ-029 Reset mid-readout SHALL abort immediately; no partial word is emitted after reset deasserts.

Configuration
REQ-030 Macro READOUT_CLR_EN defined: CLR asserts bank_clr for one cycle (with rd_en=0 and sin_hold=1); CWAIT then waits N_LAGS+1 cycles; -> IDLE.
REQ-031 Macro READOUT_CLR_EN undefined: CLR and CWAIT are absent, bank_clr is constant 0, and bank contents are preserved across readouts.

Verification
REQ-032 Bank preloaded word[i]=i*3+7, dout_ready=1, start pulse -> 32 words 7,10,...,100; idx 0..31; dout_last only on idx 31; busy low afterwards.
REQ-033 Same preload, dout_ready high one cycle in three -> identical 32-word sequence, no gaps or duplicates; rd_addr never advances while the FIFO is full.
REQ-034 sin pulses every 5 cycles during readout with upstream gating -> bank contents unchanged at readout end; sin_hold=1 exactly while busy=1.
REQ-035 READOUT_CLR_EN defined, full readout -> one bank_clr pulse after the last capture; a second readout returns 32 zeros.
REQ-036 rst_n pulsed low at ISSUE address 10, then start -> the fresh readout returns all 32 words from idx 0; no stale word appears.
REQ-037 start re-pulsed during GUARD and during DRAIN -> ignored; exactly one 32-word readout is produced.
